// File: rtl/max_pool_2x2.sv
// -----------------------------------------------------------------------------
// max_pool_2x2
//   Streaming 2x2, stride-2 pooling stage for a raster-order pixel stream
//   (row-major, column fastest). Each 2x2 block of the input frame yields one
//   pooled pixel, so an IMGROW x IMGCOL frame becomes IMGROW/2 x IMGCOL/2.
//   Only a half-width line buffer is kept; the frame is never stored.
//
//   Even rows fold horizontal pairs into the line buffer. Odd rows fold the
//   buffered pair with the current pair and emit the block result.
//
// Parameters
//   IMGCOL      input frame width  (even, >= 2)
//   IMGROW      input frame height (even, >= 2)
//   DATA_WIDTH  signed pixel width, input and output
//
// Ports
//   clk         clock, all logic on posedge
//   rst         synchronous active-low reset
//   in_valid    in_data holds a valid pixel
//   in_ready    block can take a pixel (transfer on in_valid & in_ready)
//   in_data     signed input pixel
//   out_valid   out_data holds a pooled pixel
//   out_ready   downstream accepts (transfer on out_valid & out_ready)
//   out_data    signed pooled pixel
//   frame_done  high with the last pooled pixel of a frame
//
// Configuration
//   POOL_AVG_EN  undefined: max pooling.
//                defined:   average pooling, out = (sum of 4) >>> 2.
// -----------------------------------------------------------------------------
module max_pool_2x2 #(
  parameter int IMGCOL     = 32,
  parameter int IMGROW     = 32,
  parameter int DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         frame_done
);

  localparam int HALF = IMGCOL / 2;
  localparam int CW   = (IMGCOL > 2) ? $clog2(IMGCOL) : 1;
  localparam int RW   = (IMGROW > 2) ? $clog2(IMGROW) : 1;
  localparam int KW   = (HALF > 1)   ? $clog2(HALF)   : 1;

`ifdef POOL_AVG_EN
  // Accumulator wide enough for a four-pixel signed sum. hold carries up to
  // a three-pixel partial sum on odd rows, so it shares the block width.
  localparam int AW = DATA_WIDTH + 2;
`else
  localparam int AW = DATA_WIDTH;
`endif

  // Row-parity FSM
  localparam logic [0:0] EVEN_ROW = 1'b0;
  localparam logic [0:0] ODD_ROW  = 1'b1;

  logic [0:0]                  state_q, state_d;
  logic [CW-1:0]               col_q, col_d;
  logic [RW-1:0]               row_q, row_d;
  logic signed [AW-1:0]        hold_q, hold_d;
  logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                        out_valid_q, out_valid_d;
  logic                        frame_done_q, frame_done_d;

  logic signed [AW-1:0]        lbuf_q [HALF];
  logic                        lbuf_we;
  logic signed [AW-1:0]        lbuf_wdata;
  logic [KW-1:0]               lbuf_k;
  logic signed [AW-1:0]        lbuf_rd;

  logic                        accept;
  logic                        col_last;
  logic                        row_last;
  logic signed [AW-1:0]        pix_ext;
  logic signed [AW-1:0]        blk;
  logic signed [DATA_WIDTH-1:0] result;

  // Pairwise reduction: signed max, or signed sum in average mode.
  function automatic logic signed [AW-1:0] combine(input logic signed [AW-1:0] a,
                                                   input logic signed [AW-1:0] b);
`ifdef POOL_AVG_EN
    combine = a + b;
`else
    combine = (a > b) ? a : b;
`endif
  endfunction

  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;
  assign col_last = (col_q == CW'(IMGCOL - 1));
  assign row_last = (row_q == RW'(IMGROW - 1));
  assign pix_ext  = AW'(in_data);       // sign-extending cast
  assign lbuf_k   = KW'(col_q >> 1);
  assign lbuf_rd  = lbuf_q[lbuf_k];
  assign blk      = combine(hold_q, pix_ext);

`ifdef POOL_AVG_EN
  // Floor division by 4; the quotient of four DATA_WIDTH values always fits.
  assign result = DATA_WIDTH'(blk >>> 2);
`else
  assign result = blk;
`endif

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    hold_d       = hold_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    frame_done_d = frame_done_q;
    lbuf_we      = 1'b0;
    lbuf_wdata   = combine(hold_q, pix_ext);

    // A pending result leaves once it is taken; a new one below overrides.
    if (out_valid_q && out_ready) begin
      out_valid_d  = 1'b0;
      frame_done_d = 1'b0;
    end

    if (accept) begin
      if (col_last) begin
        col_d   = '0;
        row_d   = row_last ? '0 : row_q + RW'(1);
        state_d = (state_q == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
      end else begin
        col_d = col_q + CW'(1);
      end

      if (state_q == EVEN_ROW) begin
        if (!col_q[0]) begin
          hold_d = pix_ext;
        end else begin
          lbuf_we = 1'b1;
        end
      end else begin
        if (!col_q[0]) begin
          hold_d = combine(lbuf_rd, pix_ext);
        end else begin
          out_data_d   = result;
          out_valid_d  = 1'b1;
          frame_done_d = row_last && col_last;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= EVEN_ROW;
      col_q        <= '0;
      row_q        <= '0;
      hold_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      hold_q       <= hold_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // NOTE: the line buffer has no reset; each entry is rewritten on every even
  // row before the following odd row reads it, so stale contents never leak.
  always_ff @(posedge clk) begin
    if (lbuf_we) begin
      lbuf_q[lbuf_k] <= lbuf_wdata;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_max_pool_2x2.sv
// Testbench for max_pool_2x2 on a 4x4 frame. A frame-array reference model
// derives each expected pooled pixel from the accepted input pixels; a single
// negedge monitor compares every output transfer, latency, stall stability,
// in_ready and reset state. Directed tests pin the model with literal values,
// then randomized frames run with random gaps and backpressure.
module tb_max_pool_2x2;

  localparam int C    = 4;
  localparam int R    = 4;
  localparam int DW   = 8;
  localparam int NPIX = C * R;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic signed [DW-1:0] out_data;
  logic                 frame_done;

  always #5 clk = ~clk;

  max_pool_2x2 #(.IMGCOL(C), .IMGROW(R), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .frame_done (frame_done)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct { int data; bit fd; } res_t;
  res_t exp_q[$];
  int   pix [NPIX];
  int   pos = 0;
  int   got[$];
  bit   got_fd[$];

  function automatic int pool4(input int a, input int b, input int c, input int d);
`ifdef POOL_AVG_EN
    return (a + b + c + d) >>> 2;
`else
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
`endif
  endfunction

  bit                   made_last  = 1'b0;
  bit                   post_rst   = 1'b0;
  bit                   prev_stall = 1'b0;
  logic signed [DW-1:0] prev_data;
  logic                 prev_fd;

  always @(negedge clk) begin
    res_t r;
    int   rr, cc, v;
    if (!rst) begin
      exp_q.delete();
      pos        = 0;
      made_last  = 1'b0;
      prev_stall = 1'b0;
      post_rst   = 1'b1;
    end else begin
      if (post_rst) begin
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_frame_done", frame_done, 0);
        post_rst = 1'b0;
      end
      if (made_last) begin
        check("latency_valid", out_valid, 1);
        if (exp_q.size() > 0) check("latency_data", out_data, exp_q[$].data);
        made_last = 1'b0;
      end
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_data);
        check("stall_frame_done", frame_done, prev_fd);
      end
      check("in_ready", in_ready, !out_valid || out_ready);

      if (out_valid && out_ready) begin
        got.push_back(int'(out_data));
        got_fd.push_back(frame_done);
        if (exp_q.size() == 0) begin
          check("spurious_output", out_valid, 0);
        end else begin
          r = exp_q.pop_front();
          check("out_data", out_data, r.data);
          check("frame_done", frame_done, r.fd);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_fd    = frame_done;

      if (in_valid && in_ready) begin
        pix[pos] = int'(in_data);
        rr = pos / C;
        cc = pos % C;
        if ((rr % 2 == 1) && (cc % 2 == 1)) begin
          v = pool4(pix[pos-C-1], pix[pos-C], pix[pos-1], pix[pos]);
          exp_q.push_back('{data: v, fd: (pos == NPIX - 1)});
          made_last = 1'b1;
        end
        pos = (pos + 1) % NPIX;
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  int gap_pct  = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready
  int stim [NPIX];

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(99) < 60);
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic send(input int n);
    bit acc;
    int wd;
    for (int i = 0; i < n; i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = DW'(stim[i]);
      acc = 1'b0;
      wd  = 0;
      while (!acc) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        wd++;
        if (!acc && wd > 200) begin
          check("in_accept_timeout", in_ready, 1);
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int wd = 0;
    while ((exp_q.size() != 0 || out_valid) && wd < 300) begin
      @(posedge clk);
      #1;
      wd++;
    end
    check("drain_pending", exp_q.size(), 0);
    check("drain_out_valid", out_valid, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < NPIX; i++) stim[i] = i + 1;
  endtask

  task automatic check_ramp(input string tag);
`ifdef POOL_AVG_EN
    int e [4] = '{3, 5, 11, 13};
`else
    int e [4] = '{6, 8, 14, 16};
`endif
    check({tag, "_count"}, got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_out%0d", tag, i), got[i], e[i]);
      check($sformatf("%s_fd%0d", tag, i), got_fd[i], (i == 3));
    end
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // T1: ramp frame, free-flowing output
    load_ramp();
    got.delete(); got_fd.delete();
    send(NPIX);
    drain();
    check_ramp("t1");

    // T2: signed compare with the most-negative value
    for (int i = 0; i < NPIX; i++) stim[i] = 0;
    stim[0] = -128; stim[1] = -1; stim[4] = -5; stim[5] = -128;
    got.delete(); got_fd.delete();
    send(NPIX);
    drain();
`ifdef POOL_AVG_EN
    check("t2_block", got[0], -66);
`else
    check("t2_block", got[0], -1);
`endif

    // T3: backpressure on the first result with in_valid held high
    load_ramp();
    got.delete(); got_fd.delete();
    rdy_mode = 2;
    fork
      send(NPIX);
      begin
        repeat (12) @(negedge clk);
        check("t3_in_ready", in_ready, 0);
        check("t3_out_valid", out_valid, 1);
`ifdef POOL_AVG_EN
        check("t3_held_data", out_data, 3);
`else
        check("t3_held_data", out_data, 6);
`endif
        rdy_mode = 0;
      end
    join
    drain();
    check_ramp("t3");

    // T4: two frames back-to-back
    got.delete(); got_fd.delete();
    send(NPIX);
    send(NPIX);
    drain();
    check("t4_count", got.size(), 8);
    for (int i = 0; i < 8; i++) check($sformatf("t4_fd%0d", i), got_fd[i], (i == 3 || i == 7));

    // T5: reset after 5 pixels, then a fresh frame
    got.delete(); got_fd.delete();
    send(5);
    do_reset();
    send(NPIX);
    drain();
    check_ramp("t5a");

    // T5 variant: reset while a result is pending and unaccepted
    got.delete(); got_fd.delete();
    rdy_mode = 2;
    send(6);
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    rdy_mode = 0;
    send(NPIX);
    drain();
    check_ramp("t5b");

`ifdef POOL_AVG_EN
    // T6: average rounding toward -inf
    for (int i = 0; i < NPIX; i++) stim[i] = 0;
    stim[0] = 1;  stim[1] = 2;  stim[4] = 3;  stim[5] = 5;
    stim[2] = -1; stim[3] = -1; stim[6] = -1; stim[7] = -2;
    got.delete(); got_fd.delete();
    send(NPIX);
    drain();
    check("t6_pos", got[0], 2);
    check("t6_neg", got[1], -2);
`endif

    // Randomized frames: full range, narrow range (ties), extremes only
    gap_pct  = 30;
    rdy_mode = 1;
    for (int f = 0; f < 30; f++) begin
      int kind = f % 3;
      for (int i = 0; i < NPIX; i++) begin
        case (kind)
          0:       stim[i] = int'($urandom_range(255)) - 128;
          1:       stim[i] = int'($urandom_range(4)) - 2;
          default: stim[i] = ($urandom_range(1) == 1) ? 127 : -128;
        endcase
      end
      send(NPIX);
    end
    drain();
    gap_pct  = 0;
    rdy_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
